// File: rtl/inst_fetch_if.sv
// Instruction ROM port: the fetch unit drives enable/address, the ROM answers
// with its word combinationally in the same cycle.
interface inst_fetch_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;

  modport master (output rom_ce_o, output rom_addr_o, input rom_inst_i);
  modport slave  (input rom_ce_o, input rom_addr_o, output rom_inst_i);
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and registers
// the fetched PC/instruction pair into the IF/ID boundary.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic [31:0]   new_pc,
  input  logic          branch_flag_i,
  input  logic [31:0]   branch_target_address_i,
  inst_fetch_if.master  rom,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst,
  output logic          id_adel
);

  logic        r_ce_p0;
  logic [31:0] r_pc_p0;
  logic [31:0] r_id_pc_p1;
  logic [31:0] r_id_inst_p1;
  logic        r_id_adel_p1;

  logic [31:0] w_pc_next;
  logic        w_misaligned;
  logic [31:0] w_fetch_inst;
  logic        w_unused_stall;

  assign w_unused_stall = ^stall[5:3];

  // Redirect priority: exception flush, then PC hold, then taken branch.
  always_comb begin
    w_pc_next = r_pc_p0 + PC_STEP;
    if (flush)
      w_pc_next = new_pc;
    else if (stall[0])
      w_pc_next = r_pc_p0;
    else if (branch_flag_i)
      w_pc_next = branch_target_address_i;
  end

  assign w_misaligned = (r_pc_p0[1:0] != 2'b00);
  assign w_fetch_inst = (r_ce_p0 && !w_misaligned) ? rom.rom_inst_i : 32'h0;

  // ---- stage p0: PC / ROM enable ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_p0 <= 1'b0;
      r_pc_p0 <= RESET_PC;
    end else begin
      r_ce_p0 <= 1'b1;
      if (r_ce_p0)
        r_pc_p0 <= w_pc_next;
    end
  end

  // ---- stage p1: IF/ID boundary ----
  always_ff @(posedge clk) begin
    if (rst || flush || (stall[1] && !stall[2])) begin
      r_id_pc_p1   <= 32'h0;
      r_id_inst_p1 <= 32'h0;
      r_id_adel_p1 <= 1'b0;
    end else if (!stall[1]) begin
      r_id_pc_p1   <= r_pc_p0;
      r_id_inst_p1 <= w_fetch_inst;
      r_id_adel_p1 <= w_misaligned;
    end
  end

  assign rom.rom_ce_o   = r_ce_p0;
  assign rom.rom_addr_o = r_pc_p0;
  assign id_pc          = r_id_pc_p1;
  assign id_inst        = r_id_inst_p1;
  assign id_adel        = r_id_adel_p1;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic        m_ce;
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_adel;

  inst_fetch_if rom_if ();

  inst_fetch #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom                     (rom_if.master),
    .id_pc                   (id_pc),
    .id_inst                 (id_inst),
    .id_adel                 (id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]} + 32'h1357_9BDF;
  endfunction

  always_comb begin
    rom_if.rom_inst_i = 32'h0;
    if (rom_if.rom_ce_o)
      rom_if.rom_inst_i = rom_word(rom_if.rom_addr_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, advances the model and compares all outputs.
  task automatic step(input logic r, input logic [5:0] st, input logic fl,
                      input logic [31:0] npc, input logic br, input logic [31:0] tgt);
    logic        ce_n, adel_n;
    logic [31:0] pc_n, idpc_n, inst_n;
    rst = r; stall = st; flush = fl; new_pc = npc;
    branch_flag_i = br; branch_target_address_i = tgt;
    ce_n = m_ce; pc_n = m_pc; idpc_n = m_id_pc; inst_n = m_id_inst; adel_n = m_id_adel;
    if (r) begin
      ce_n = 0; pc_n = RESET_PC; idpc_n = 0; inst_n = 0; adel_n = 0;
    end else begin
      ce_n = 1;
      if (m_ce) begin
        if (fl)          pc_n = npc;
        else if (st[0])  pc_n = m_pc;
        else if (br)     pc_n = tgt;
        else             pc_n = m_pc + PC_STEP;
      end
      if (fl || (st[1] && !st[2])) begin
        idpc_n = 0; inst_n = 0; adel_n = 0;
      end else if (!st[1]) begin
        idpc_n = m_pc;
        adel_n = (m_pc % 4) != 0;
        inst_n = (adel_n || !m_ce) ? 32'h0 : rom_word(m_pc);
      end
    end
    @(posedge clk);
    #1;
    m_ce = ce_n; m_pc = pc_n; m_id_pc = idpc_n; m_id_inst = inst_n; m_id_adel = adel_n;
    check_eq("rom_ce",   {31'h0, rom_if.rom_ce_o}, {31'h0, m_ce});
    check_eq("rom_addr", rom_if.rom_addr_o, m_pc);
    check_eq("id_pc",    id_pc, m_id_pc);
    check_eq("id_inst",  id_inst, m_id_inst);
    check_eq("id_adel",  {31'h0, id_adel}, {31'h0, m_id_adel});
  endtask

  task automatic idle();
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] t, np;
    logic [5:0]  st;
    m_ce = 0; m_pc = RESET_PC; m_id_pc = 0; m_id_inst = 0; m_id_adel = 0;

    // reset release and sequential fetch
    step(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("reset_ce", {31'h0, rom_if.rom_ce_o}, 32'h0);
    idle();
    check_eq("start_addr0", rom_if.rom_addr_o, 32'h0);
    idle();
    check_eq("start_addr4", rom_if.rom_addr_o, 32'h4);
    check_eq("start_W0", id_inst, rom_word(32'h0));
    idle();
    check_eq("start_addr8", rom_if.rom_addr_o, 32'h8);
    check_eq("start_W1", id_inst, rom_word(32'h4));

    // stall hold, bubble, release
    step(1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("stall_pc", rom_if.rom_addr_o, 32'h8);
    check_eq("stall_hold_pc", id_pc, 32'h4);
    step(1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("bubble_pc", id_pc, 32'h0);
    check_eq("bubble_inst", id_inst, 32'h0);
    idle();
    check_eq("resume_idpc", id_pc, 32'h8);
    idle();
    check_eq("pre_branch_pc", rom_if.rom_addr_o, 32'h10);

    // branch
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    check_eq("br_addr", rom_if.rom_addr_o, 32'h40);
    check_eq("br_idpc", id_pc, 32'h10);
    idle();
    check_eq("br_idpc2", id_pc, 32'h40);

    // flush over branch
    step(1'b0, 6'b0, 1'b1, 32'h180, 1'b1, 32'h40);
    check_eq("fl_addr", rom_if.rom_addr_o, 32'h180);
    check_eq("fl_idpc", id_pc, 32'h0);

    // misaligned fetch
    step(1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h22);
    idle();
    check_eq("mis_adel", {31'h0, id_adel}, 32'h1);
    check_eq("mis_inst", id_inst, 32'h0);
    check_eq("mis_idpc", id_pc, 32'h22);
    idle();

    // wrap
    step(1'b0, 6'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    idle();
    check_eq("wrap_addr", rom_if.rom_addr_o, 32'h0);
    check_eq("wrap_idpc", id_pc, 32'hFFFF_FFFC);

    // reset mid-run with stall and branch active
    step(1'b1, 6'b000111, 1'b0, 32'h0, 1'b1, 32'h80);
    check_eq("mrst_ce", {31'h0, rom_if.rom_ce_o}, 32'h0);
    check_eq("mrst_addr", rom_if.rom_addr_o, RESET_PC);
    check_eq("mrst_idpc", id_pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      t  = $urandom;
      np = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) np[1:0] = 2'b00;
      st = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      step($urandom_range(0, 63) == 0, st, $urandom_range(0, 15) == 0, np,
           $urandom_range(0, 5) == 0, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator for the 5-stage pipeline: owns the PC and drives the chip-enable and address of the instruction ROM.
- The ROM returns its word combinationally in the same cycle.
- Registers the fetched PC/instruction pair into the IF/ID boundary for the decode stage.
- Handles stall, branch redirect, exception flush and misaligned-fetch detection.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  6  pipeline stall vector; bit0 = hold PC, bit1 = hold IF, bit2 = hold ID; bits 3-5 ignored.
- flush  input  1  exception flush from ctrl; highest priority.
- new_pc  input  32  exception/eret redirect target, valid with flush.
- branch_flag_i  input  1  taken branch/jump resolved in ID.
- branch_target_address_i  input  32  branch target, valid with branch_flag_i.
- rom_inst_i  input  32  instruction word from ROM (combinational response to rom_addr_o).
- rom_ce_o  output  1  ROM chip enable; 1 = enabled.
- rom_addr_o  output  32  fetch byte address; equals current PC.
- id_pc  output  32  PC of the instruction presented to ID.
- id_inst  output  32  instruction presented to ID.
- id_adel  output  1  fetch address misaligned; id_inst forced to zero.

Behaviour:
- Reset (rst=1 at an edge): rom_ce_o<=0, pc<=RESET_PC, id_pc<=0, id_inst<=0, id_adel<=0.
  - Reset mid-operation discards any pending redirect.
- Start-up: rom_ce_o<=1 on the first edge with rst=0.
  - While rom_ce_o=0: PC is held at RESET_PC and the ROM returns zero.
  - First real fetch is RESET_PC, in the cycle after rst deasserts.
- PC update, only while rom_ce_o=1, priority high to low:
  - flush=1 -> pc<=new_pc.
  - stall[0]=1 -> pc held.
  - branch_flag_i=1 -> pc<=branch_target_address_i.
  - else -> pc<=pc+PC_STEP, modulo 2^32 (32'hFFFFFFFC wraps to 0).
- Simultaneous flush and branch: flush wins and the branch is lost. Simultaneous stall[0] and branch: branch is dropped.
  - ID re-asserts the branch because ID is also stalled; the bench must hold the branch inputs stable during stall.
- rom_addr_o = pc (combinational from the register); no address register separate from PC.
- IF/ID register, per edge with rst=0, priority high to low:
  - flush=1 -> id_pc<=0, id_inst<=0, id_adel<=0.
  - stall[1]=1 and stall[2]=0 -> insert bubble: id_pc<=0, id_inst<=0, id_adel<=0.
  - stall[1]=1 and stall[2]=1 -> hold all three.
  - stall[1]=0 -> id_pc<=pc, id_inst<=rom_inst_i, id_adel<=0.
    - If pc[1:0]!=2'b00: id_inst<=0 and id_adel<=1 instead.
    - If rom_ce_o=0: captured values are pc=RESET_PC, inst=0.
- Misaligned PC continues incrementing by PC_STEP until flush redirects it; the block does not self-correct.
- Latency: an instruction at address A appears on id_inst exactly one edge after rom_addr_o=A with no stall. A redirect takes effect on rom_addr_o one edge after branch_flag_i/flush.
- No combinational path from any input to rom_ce_o or rom_addr_o.

Test Plan:
- Reset release, ROM holds words W0..W3 at 0x0,0x4,0x8,0xC:
  - rst=1 for 2 cycles, then 0 -> rom_ce_o rises 1 edge later.
  - rom_addr_o sequence 0,4,8,C.
  - id_inst = W0,W1,W2 each one edge behind, with matching id_pc.
- Stall, with pc=0x8: stall=6'b000111 for 2 cycles -> pc stays 0x8, id_pc/id_inst held. Then stall=6'b000011 for 1 cycle -> id_pc=0, id_inst=0 (bubble). Stall release -> fetch resumes at 0x8 without loss.
- Branch: branch_flag_i=1, target=0x40 at pc=0x10 -> next rom_addr_o=0x40 and id_pc=0x10 on that edge. Following edge id_pc=0x40.
- Flush over branch: flush=1, new_pc=0x180, branch_flag_i=1, target=0x40 same cycle -> rom_addr_o=0x180, id_pc=0, id_inst=0, id_adel=0.
- Misaligned fetch and wrap:
  - branch to 0x22 -> next capture id_adel=1, id_inst=0, id_pc=0x22.
  - Separately, pc=0xFFFFFFFC with no stall -> next rom_addr_o=0x00000000.
- Reset mid-run: rst=1 while stall and branch are active -> next edge rom_ce_o=0, rom_addr_o=RESET_PC, all id_* zero.
